// File: rtl/ysyx_220053_lsu.sv
// Load/store unit: one outstanding request, valid/ready handshakes on the EXU and memory sides.
// Handles byte-lane alignment, write masks, load extension and misaligned/illegal detection.
module ysyx_220053_lsu #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [2:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wmask,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int NB     = XLEN / 8;
    localparam int OFFW   = $clog2(NB);
    localparam bit NARROW = (XLEN == 32);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_ERR
    } state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [OFFW-1:0]  off_q;

    logic [OFFW-1:0]  req_off;
    logic [3:0]       req_bytes;
    logic [NB-1:0]    size_mask;
    logic [NB-1:0]    req_wmask;
    logic [XLEN-1:0]  req_wshift;
    logic             req_illegal;
    logic             req_misaligned;

    assign req_off = req_addr[OFFW-1:0];

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        req_bytes = 4'd8;
        size_mask = '1;
        case (req_op[1:0])
            2'b00:   begin req_bytes = 4'd4; size_mask = NB'(15); end
            2'b01:   begin req_bytes = 4'd1; size_mask = NB'(1);  end
            2'b10:   begin req_bytes = 4'd2; size_mask = NB'(3);  end
            default: begin req_bytes = 4'd8; size_mask = '1;      end
        endcase
    end

    // op[2] selects zero-extension on loads only; a store with 111 is a plain doubleword.
    assign req_illegal    = (!req_wen && req_op == 3'b111) || (NARROW && req_op[1:0] == 2'b11);
    assign req_misaligned = (req_off & OFFW'(req_bytes - 4'd1)) != '0;
    assign req_wmask      = req_wen ? (size_mask << req_off) : '0;
    assign req_wshift     = req_wdata << {req_off, 3'b000};

    logic [XLEN-1:0]  rd_shift;
    logic [63:0]      rd_wide;
    logic [63:0]      rd_ext;
    logic             rd_sext;
    logic [XLEN-1:0]  load_data;

    // Widen to 64 bits first so the same extension logic serves both data widths.
    assign rd_shift = mem_rdata >> {off_q, 3'b000};
    assign rd_wide  = 64'(rd_shift);
    assign rd_sext  = !op_q[2];

    always_comb begin
        rd_ext = rd_wide;
        case (op_q[1:0])
            2'b01:   rd_ext = {{56{rd_sext & rd_wide[7]}},  rd_wide[7:0]};
            2'b10:   rd_ext = {{48{rd_sext & rd_wide[15]}}, rd_wide[15:0]};
            2'b00:   rd_ext = {{32{rd_sext & rd_wide[31]}}, rd_wide[31:0]};
            default: rd_ext = rd_wide;
        endcase
    end

    assign load_data = rd_ext[XLEN-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_valid  <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            op_q       <= '0;
            off_q      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        op_q      <= req_op;
                        off_q     <= req_off;
                        if (req_illegal || req_misaligned) begin
                            state      <= S_ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= S_REQ;
                            mem_valid <= 1'b1;
                            mem_wen   <= req_wen;
                            mem_addr  <= {req_addr[ADDR_W-1:OFFW], OFFW'(0)};
                            mem_wdata <= req_wshift;
                            mem_wmask <= req_wmask;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        state      <= S_RESP;
                        mem_valid  <= 1'b0;
                        mem_wen    <= 1'b0;
                        mem_wmask  <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= mem_wen ? '0 : load_data;
                    end
                end
                S_RESP, S_ERR: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
